bcd_serial_adder_ctrl: RTL and testbench
========================================

Name: bcd_serial_adder_ctrl

Overview:
Sequencer that performs multi-digit packed-BCD addition and subtraction by time-sharing one single-digit bcd_adder_core, one digit per clock. It latches two DIGITS-wide operands on a start request and feeds the core least-significant digit first, rippling the decimal carry through an internal register. It collects the sum digits into a result register. It is the digit-serial arithmetic unit between the calculator register file and the shared BCD adder core.

Parameters:
DIGITS, 4, number of BCD digits per operand (>=2); data width W = 4*DIGITS

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  request; sampled only in IDLE
op_sub  input  1  0 = A+B, 1 = A-B (nine's complement of B, carry-in 1); sampled with start
op_a  input  W  packed BCD operand A, digit 0 in bits [3:0]
op_b  input  W  packed BCD operand B
core_a  output  4  digit of A to the core
core_b  output  4  digit of B (or 9-B) to the core
core_cin  output  1  carry to the core
core_s  input  4  core BCD sum digit
core_cout  input  1  core decimal carry
busy  output  1  high while an operation is in progress
done  output  1  one-cycle pulse when result is valid
result  output  W  packed BCD result
carry_out  output  1  final decimal carry (add: overflow; sub: 1 = non-negative)
neg  output  1  sub only: 1 = A<B, result holds the ten's complement
err  output  1  a latched operand digit was >9; operation aborted

Behaviour:
- Reset (async, rst_n=0): state IDLE; busy=0, done=0, result=0, carry_out=0, neg=0, err=0, core_a/core_b/core_cin=0, digit index=0.
- States: IDLE, RUN, DONE.
- IDLE: core_* outputs driven 0. On start=1 at a clock edge:
  - Latch op_a, op_b, op_sub. Clear err.
  - If any digit of op_a or op_b >9: set err=1, result=0, carry_out=0, neg=0, go to DONE.
  - Otherwise: carry register = op_sub, index=0, go to RUN.
- RUN, one digit per cycle, combinational drive from registers:
  - core_a = A digit[index].
  - core_b = B digit[index], or 9-B digit[index] when sub.
  - core_cin = carry register.
  - At each edge: result digit[index] <= core_s; carry <= core_cout; index++.
  - After the edge that writes digit DIGITS-1, go to DONE.
- DONE (one cycle):
  - done=1; carry_out = final carry; neg = op_sub & ~final carry (0 for add).
  - Then go to IDLE.
  - result, carry_out, neg and err hold until the next accepted start.
- busy=1 in RUN and DONE, 0 in IDLE. start is ignored while busy=1; it is not queued.
- Latency: start accepted at edge k, done high during the cycle after edge k+DIGITS. Throughput is one operation per DIGITS+2 cycles.
- Error path: done asserts the cycle after start, with latency 1.
- Result digits not yet written during RUN keep their previous values. Consumers read result only on or after done.
- The core is combinational; the controller assumes core_s/core_cout settle within one cycle. No handshake to the core.
- Subtraction uses nine's complement with end-around carry-in of 1:
  - final carry 1 means A>=B and result = A-B;
  - final carry 0 means result = 10^DIGITS-(B-A), with neg=1.
- Addition overflow: carry_out=1; result = low DIGITS digits.
- Reset asserted mid-RUN aborts immediately to the reset state with no done pulse.

Test Plan:
- DIGITS=4, add op_a=16'h1234, op_b=16'h5678 -> done 5 cycles after start edge, result=16'h6912, carry_out=0, neg=0, err=0; core_a sequence 4,3,2,1.
- Add 16'h9999 + 16'h0001 -> carry ripples every digit (core_cin=1 on digits 1..3), result=16'h0000, carry_out=1.
- Sub 16'h5000 - 16'h1234 -> core_b sequence 5,6,7,8, first core_cin=1, result=16'h3766, carry_out=1, neg=0. Sub 16'h1234 - 16'h5000 -> result=16'h6234, carry_out=0, neg=1. Sub 16'h0042 - 16'h0042 -> result=16'h0000, carry_out=1, neg=0.
- Invalid digit: op_a=16'h12A4 -> done the cycle after start, err=1, result=0, core_a stays 0. Next valid start clears err.
- start held high throughout and re-pulsed mid-RUN -> operation unaffected, exactly one done per accepted start, busy=1 from accept to done inclusive. Second op accepted only in IDLE.
- rst_n pulled low during RUN digit 2 -> all outputs 0 immediately (asynchronously), no done. A fresh start afterwards completes correctly (16'h0808+16'h0202=16'h1010).

Source files
------------

// File: rtl/bcd_serial_adder_ctrl.sv
// Digit-serial packed-BCD add/subtract sequencer. One shared single-digit
// BCD adder core is fed one digit per clock, least-significant digit first,
// and the decimal carry ripples through carry_q between digits.
//
// Handshake: a request is taken when start=1 at a clock edge while the unit
// is idle (busy=0); start is ignored, not queued, while busy=1. done is a
// one-cycle pulse; result/carry_out/neg/err are valid from done onwards and
// hold until the next accepted request.
module bcd_serial_adder_ctrl #(
  parameter int DIGITS = 4,
  localparam int W  = 4 * DIGITS,
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic         op_sub,
  input  logic [W-1:0] op_a,
  input  logic [W-1:0] op_b,
  output logic [3:0]   core_a,
  output logic [3:0]   core_b,
  output logic         core_cin,
  input  logic [3:0]   core_s,
  input  logic         core_cout,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] result,
  output logic         carry_out,
  output logic         neg,
  output logic         err,
  output logic [1:0]   dbg_state_o
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e         state_q, state_d;
  logic [IW-1:0]  idx_q, idx_d;
  logic [W-1:0]   a_q, a_d;
  logic [W-1:0]   b_q, b_d;
  logic           sub_q, sub_d;
  logic           carry_q, carry_d;
  logic [W-1:0]   result_q, result_d;
  logic           carry_out_q, carry_out_d;
  logic           neg_q, neg_d;
  logic           err_q, err_d;
  logic [3:0]     dig_a, dig_b;
  logic           last_digit;

  // True when any 4-bit digit of v is outside 0..9.
  function automatic logic has_bad_digit(input logic [W-1:0] v);
    has_bad_digit = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (v[4*i +: 4] > 4'd9) has_bad_digit = 1'b1;
    end
  endfunction

  // Select the current digit of each latched operand.
  always_comb begin
    dig_a = 4'd0;
    dig_b = 4'd0;
    for (int i = 0; i < DIGITS; i++) begin
      if (idx_q == IW'(i)) begin
        dig_a = a_q[4*i +: 4];
        dig_b = b_q[4*i +: 4];
      end
    end
  end

  assign last_digit = (idx_q == IW'(DIGITS - 1));

  // Core drive: only meaningful in RUN, held at zero otherwise.
  always_comb begin
    core_a   = 4'd0;
    core_b   = 4'd0;
    core_cin = 1'b0;
    if (state_q == S_RUN) begin
      core_a   = dig_a;
      core_b   = sub_q ? (4'd9 - dig_b) : dig_b;
      core_cin = carry_q;
    end
  end

  // Next-state and datapath update for the sequencer.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    a_d         = a_q;
    b_d         = b_q;
    sub_d       = sub_q;
    carry_d     = carry_q;
    result_d    = result_q;
    carry_out_d = carry_out_q;
    neg_d       = neg_q;
    err_d       = err_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          a_d   = op_a;
          b_d   = op_b;
          sub_d = op_sub;
          err_d = 1'b0;
          if (has_bad_digit(op_a) || has_bad_digit(op_b)) begin
            err_d       = 1'b1;
            result_d    = '0;
            carry_out_d = 1'b0;
            neg_d       = 1'b0;
            state_d     = S_DONE;
          end else begin
            carry_d = op_sub;
            idx_d   = '0;
            state_d = S_RUN;
          end
        end
      end
      S_RUN: begin
        for (int i = 0; i < DIGITS; i++) begin
          if (idx_q == IW'(i)) result_d[4*i +: 4] = core_s;
        end
        carry_d = core_cout;
        if (last_digit) begin
          // Final carry is captured here so it is already valid while done is high.
          carry_out_d = core_cout;
          neg_d       = sub_q & ~core_cout;
          idx_d       = '0;
          state_d     = S_DONE;
        end else begin
          idx_d = idx_q + IW'(1);
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers, cleared asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      idx_q       <= '0;
      a_q         <= '0;
      b_q         <= '0;
      sub_q       <= 1'b0;
      carry_q     <= 1'b0;
      result_q    <= '0;
      carry_out_q <= 1'b0;
      neg_q       <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      a_q         <= a_d;
      b_q         <= b_d;
      sub_q       <= sub_d;
      carry_q     <= carry_d;
      result_q    <= result_d;
      carry_out_q <= carry_out_d;
      neg_q       <= neg_d;
      err_q       <= err_d;
    end
  end

  assign busy        = (state_q != S_IDLE);
  assign done        = (state_q == S_DONE);
  assign result      = result_q;
  assign carry_out   = carry_out_q;
  assign neg         = neg_q;
  assign err         = err_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_bcd_serial_adder_ctrl.sv
// Directed bench for bcd_serial_adder_ctrl (DIGITS=4) with a behavioural
// single-digit BCD adder core hooked to the core_* ports.
module tb_bcd_serial_adder_ctrl;

  localparam int DIGITS = 4;
  localparam int W      = 16;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic         op_sub;
  logic [W-1:0] op_a;
  logic [W-1:0] op_b;
  logic [3:0]   core_a;
  logic [3:0]   core_b;
  logic         core_cin;
  logic [3:0]   core_s;
  logic         core_cout;
  logic         busy;
  logic         done;
  logic [W-1:0] result;
  logic         carry_out;
  logic         neg;
  logic         err;
  logic [1:0]   dbg_state_o;

  int n_cmp;
  int n_err;
  int done_cnt;
  int exp_ops;
  logic [W-1:0] exp_q[$];

  bcd_serial_adder_ctrl #(.DIGITS(DIGITS)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .op_sub      (op_sub),
    .op_a        (op_a),
    .op_b        (op_b),
    .core_a      (core_a),
    .core_b      (core_b),
    .core_cin    (core_cin),
    .core_s      (core_s),
    .core_cout   (core_cout),
    .busy        (busy),
    .done        (done),
    .result      (result),
    .carry_out   (carry_out),
    .neg         (neg),
    .err         (err),
    .dbg_state_o (dbg_state_o)
  );

  // Behavioural single-digit BCD adder core.
  logic [4:0] core_raw;
  logic [4:0] core_adj;
  assign core_raw  = {1'b0, core_a} + {1'b0, core_b} + {4'd0, core_cin};
  assign core_adj  = core_raw - 5'd10;
  assign core_cout = (core_raw > 5'd9);
  assign core_s    = core_cout ? core_adj[3:0] : core_raw[3:0];

  // Clock and watchdog.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required finish earlier");
    $fatal(1, "watchdog");
  end

  // Count done pulses, sampled away from the active edge.
  always @(negedge clk) begin
    if (done === 1'b1) done_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h required %0h", tag, got, exp);
    end
  endtask

  // Issue one request, follow it to done and check everything observed.
  task automatic run_op(input string tag, input logic sub,
                        input logic [15:0] a, input logic [15:0] b,
                        input logic [15:0] e_res, input logic e_co,
                        input logic e_neg, input logic e_err,
                        input logic [15:0] e_ca, input logic [15:0] e_cb,
                        input logic [3:0] e_cin, input logic hold);
    logic [15:0] sa;
    logic [15:0] sb;
    logic [3:0]  sc;
    int          lat;
    int          n;
    @(negedge clk);
    start  = 1'b1;
    op_sub = sub;
    op_a   = a;
    op_b   = b;
    exp_q.push_back(e_res);
    exp_ops++;
    @(posedge clk);
    @(negedge clk);
    if (hold) begin
      op_a   = 16'h9999;
      op_b   = 16'h9999;
      op_sub = ~sub;
    end else begin
      start = 1'b0;
    end
    lat = 1;
    n   = 0;
    sa  = '0;
    sb  = '0;
    sc  = '0;
    while (done !== 1'b1 && lat < 20) begin
      chk({tag, " busy_run"}, busy, 1);
      if (n < 4) begin
        sa[4*n +: 4] = core_a;
        sb[4*n +: 4] = core_b;
        sc[n]        = core_cin;
      end
      n++;
      @(negedge clk);
      lat++;
      if (hold && lat == 2) start = 1'b0;
      if (hold && lat == 3) start = 1'b1;
    end
    chk({tag, " latency"}, lat, e_err ? 1 : DIGITS + 1);
    chk({tag, " busy_done"}, busy, 1);
    chk({tag, " result"}, result, exp_q.pop_front());
    chk({tag, " carry_out"}, carry_out, e_co);
    chk({tag, " neg"}, neg, e_neg);
    chk({tag, " err"}, err, e_err);
    if (e_err) begin
      chk({tag, " core_a_zero"}, core_a, 0);
    end else begin
      chk({tag, " core_a_seq"}, sa, e_ca);
      chk({tag, " core_b_seq"}, sb, e_cb);
      chk({tag, " core_cin_seq"}, sc, e_cin);
    end
    start = 1'b0;
    @(negedge clk);
    chk({tag, " done_pulse"}, done, 0);
    chk({tag, " idle_busy"}, busy, 0);
  endtask

  int cnt_before;

  initial begin
    n_cmp    = 0;
    n_err    = 0;
    done_cnt = 0;
    exp_ops  = 0;
    rst_n    = 1'b0;
    start    = 1'b0;
    op_sub   = 1'b0;
    op_a     = '0;
    op_b     = '0;
    #3;
    chk("rst busy", busy, 0);
    chk("rst done", done, 0);
    chk("rst result", result, 0);
    chk("rst carry_out", carry_out, 0);
    chk("rst neg", neg, 0);
    chk("rst err", err, 0);
    chk("rst core", {core_a, core_b, core_cin}, 0);
    chk("rst state", dbg_state_o, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    //      tag        sub   a         b         res       co    neg   err   core_a    core_b    cin      hold
    run_op("add1",     1'b0, 16'h1234, 16'h5678, 16'h6912, 1'b0, 1'b0, 1'b0, 16'h1234, 16'h5678, 4'b0110, 1'b0);
    run_op("add_rip",  1'b0, 16'h9999, 16'h0001, 16'h0000, 1'b1, 1'b0, 1'b0, 16'h9999, 16'h0001, 4'b1110, 1'b0);
    run_op("sub_pos",  1'b1, 16'h5000, 16'h1234, 16'h3766, 1'b1, 1'b0, 1'b0, 16'h5000, 16'h8765, 4'b0001, 1'b0);
    run_op("sub_neg",  1'b1, 16'h1234, 16'h5000, 16'h6234, 1'b0, 1'b1, 1'b0, 16'h1234, 16'h4999, 4'b1111, 1'b0);
    run_op("bad_dig",  1'b0, 16'h12A4, 16'h0001, 16'h0000, 1'b0, 1'b0, 1'b1, 16'h0000, 16'h0000, 4'b0000, 1'b0);
    run_op("sub_zero", 1'b1, 16'h0042, 16'h0042, 16'h0000, 1'b1, 1'b0, 1'b0, 16'h0042, 16'h9957, 4'b1111, 1'b0);
    run_op("hold",     1'b0, 16'h1234, 16'h5678, 16'h6912, 1'b0, 1'b0, 1'b0, 16'h1234, 16'h5678, 4'b0110, 1'b1);

    // Reset in the middle of a run: accept, digit0, digit1, then reset in digit2.
    cnt_before = done_cnt;
    @(negedge clk);
    start  = 1'b1;
    op_sub = 1'b0;
    op_a   = 16'h1111;
    op_b   = 16'h2222;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("mid core_a_digit2", core_a, 1);
    #1;
    rst_n = 1'b0;
    #1;
    chk("mid busy", busy, 0);
    chk("mid done", done, 0);
    chk("mid result", result, 0);
    chk("mid core", {core_a, core_b, core_cin}, 0);
    chk("mid flags", {carry_out, neg, err}, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("mid no_done", done_cnt, cnt_before);

    run_op("after_rst", 1'b0, 16'h0808, 16'h0202, 16'h1010, 1'b0, 1'b0, 1'b0, 16'h0808, 16'h0202, 4'b1010, 1'b0);

    repeat (2) @(negedge clk);
    chk("done_count", done_cnt, exp_ops);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
